// File: rtl/axis_frame_len_check.sv
// AXI4-Stream frame length checker: marks short frames bad on their last beat,
// truncates over-long frames (forced tlast+tuser) and reports one status pulse per input frame.
module axis_frame_len_check #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    input  logic [LEN_WIDTH-1:0]  length_min,
    input  logic [LEN_WIDTH-1:0]  length_max,
    output logic                  frame_done,
    output logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  frame_bad_short,
    output logic                  frame_bad_long
);

    typedef enum logic [0:0] {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_long_sticky;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_out_user;
    logic                  r_done;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_bad_short;
    logic                  r_bad_long;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [LEN_WIDTH-1:0]  w_n;
    logic                  w_short_now;
    logic                  w_trunc_now;

    // Ready, beat acceptance and the saturating count of the beat being accepted.
    always_comb begin
        w_in_ready  = 1'b1;
        w_n         = r_cnt;
        if (r_state == ST_DISCARD) begin
            w_in_ready = 1'b1;
        end else begin
            w_in_ready = output_axis_tready | ~r_out_valid;
        end
        if (r_cnt == {LEN_WIDTH{1'b1}}) begin
            w_n = r_cnt;
        end else begin
            w_n = r_cnt + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        end
        w_accept    = input_axis_tvalid & w_in_ready;
        w_short_now = (length_min != {LEN_WIDTH{1'b0}}) && (w_n < length_min);
        w_trunc_now = (length_max != {LEN_WIDTH{1'b0}}) && (w_n >= length_max);
    end

    // Frame state machine, output register and per-frame status, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_PASS;
            r_cnt         <= {LEN_WIDTH{1'b0}};
            r_long_sticky <= 1'b0;
            r_out_data    <= {DATA_WIDTH{1'b0}};
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_user    <= 1'b0;
            r_done        <= 1'b0;
            r_len         <= {LEN_WIDTH{1'b0}};
            r_bad_short   <= 1'b0;
            r_bad_long    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A consumed beat empties the register unless a new PASS beat reloads it below.
            if (output_axis_tready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_PASS: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= input_axis_tdata;
                        if (input_axis_tlast) begin
                            r_out_last  <= 1'b1;
                            r_out_user  <= input_axis_tuser | w_short_now;
                            r_cnt       <= {LEN_WIDTH{1'b0}};
                            r_done      <= 1'b1;
                            r_len       <= w_n;
                            r_bad_short <= w_short_now;
                            r_bad_long  <= 1'b0;
                        end else if (w_trunc_now) begin
                            r_out_last    <= 1'b1;
                            r_out_user    <= 1'b1;
                            r_cnt         <= w_n;
                            r_state       <= ST_DISCARD;
                            r_long_sticky <= 1'b1;
                        end else begin
                            r_out_last <= 1'b0;
                            r_out_user <= input_axis_tuser;
                            r_cnt      <= w_n;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_accept) begin
                        if (input_axis_tlast) begin
                            r_done        <= 1'b1;
                            r_len         <= w_n;
                            r_bad_short   <= 1'b0;
                            r_bad_long    <= r_long_sticky;
                            r_cnt         <= {LEN_WIDTH{1'b0}};
                            r_state       <= ST_PASS;
                            r_long_sticky <= 1'b0;
                        end else begin
                            r_cnt <= w_n;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_PASS;
                    r_cnt         <= {LEN_WIDTH{1'b0}};
                    r_long_sticky <= 1'b0;
                end
            endcase
        end
    end

    assign input_axis_tready  = w_in_ready;
    assign output_axis_tdata  = r_out_data;
    assign output_axis_tvalid = r_out_valid;
    assign output_axis_tlast  = r_out_last;
    assign output_axis_tuser  = r_out_user;
    assign frame_done         = r_done;
    assign frame_len          = r_len;
    assign frame_bad_short    = r_bad_short;
    assign frame_bad_long     = r_bad_long;

endmodule

// File: tb/tb_axis_frame_len_check.sv
// Self-checking bench for axis_frame_len_check: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_axis_frame_len_check;
    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] input_axis_tdata;
    logic          input_axis_tvalid;
    logic          input_axis_tready;
    logic          input_axis_tlast;
    logic          input_axis_tuser;
    logic [DW-1:0] output_axis_tdata;
    logic          output_axis_tvalid;
    logic          output_axis_tready;
    logic          output_axis_tlast;
    logic          output_axis_tuser;
    logic [LW-1:0] length_min;
    logic [LW-1:0] length_max;
    logic          frame_done;
    logic [LW-1:0] frame_len;
    logic          frame_bad_short;
    logic          frame_bad_long;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;

    logic [DW-1:0] in_d[$];
    bit            in_u[$];
    int            in_cyc[$];
    logic [DW-1:0] obs_d[$];
    bit            obs_l[$], obs_u[$];
    int            obs_cyc[$];
    int            obs_len[$], obs_done_cyc[$];
    bit            obs_short[$], obs_long[$];
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$], exp_u[$];
    int            exp_len[$];
    bit            exp_short[$], exp_long[$];

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    bit            prev_l, prev_u;

    axis_frame_len_check #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
        .input_axis_tready(input_axis_tready), .input_axis_tlast(input_axis_tlast),
        .input_axis_tuser(input_axis_tuser),
        .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
        .output_axis_tready(output_axis_tready), .output_axis_tlast(output_axis_tlast),
        .output_axis_tuser(output_axis_tuser),
        .length_min(length_min), .length_max(length_max),
        .frame_done(frame_done), .frame_len(frame_len),
        .frame_bad_short(frame_bad_short), .frame_bad_long(frame_bad_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output-side ready pattern: 0 = always ready, 1 = toggling, 2 = random.
    initial begin
        output_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: output_axis_tready = 1'b1;
                1: output_axis_tready = ~output_axis_tready;
                default: output_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: records handshakes and status pulses, checks hold-while-stalled and ready rule.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (input_axis_tvalid && input_axis_tready) in_cyc.push_back(cyc);
            if (output_axis_tvalid && output_axis_tready) begin
                obs_d.push_back(output_axis_tdata);
                obs_l.push_back(output_axis_tlast);
                obs_u.push_back(output_axis_tuser);
                obs_cyc.push_back(cyc);
            end
            if (frame_done) begin
                obs_len.push_back(int'(frame_len));
                obs_short.push_back(frame_bad_short);
                obs_long.push_back(frame_bad_long);
                obs_done_cyc.push_back(cyc);
            end
            if (prev_stall) begin
                checks++;
                if (!output_axis_tvalid || output_axis_tdata !== prev_d ||
                    output_axis_tlast !== prev_l || output_axis_tuser !== prev_u) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b d=%h l=%0b u=%0b, expected v=1 d=%h l=%0b u=%0b",
                             output_axis_tvalid, output_axis_tdata, output_axis_tlast,
                             output_axis_tuser, prev_d, prev_l, prev_u);
                end
            end
            checks++;
            if (!input_axis_tready && !(output_axis_tvalid && !output_axis_tready)) begin
                failures++;
                $display("FAIL ready_rule: in_ready=0 with out_valid=%0b out_ready=%0b",
                         output_axis_tvalid, output_axis_tready);
            end
            prev_stall = output_axis_tvalid && !output_axis_tready;
            prev_d = output_axis_tdata;
            prev_l = output_axis_tlast;
            prev_u = output_axis_tuser;
        end
    end

    task automatic clear_all();
        in_cyc.delete(); obs_d.delete(); obs_l.delete(); obs_u.delete(); obs_cyc.delete();
        obs_len.delete(); obs_short.delete(); obs_long.delete(); obs_done_cyc.delete();
        exp_d.delete(); exp_l.delete(); exp_u.delete();
        exp_len.delete(); exp_short.delete(); exp_long.delete();
    endtask

    // Reference model: whole-frame view of what the checker should emit for in_d/in_u.
    task automatic model_frame(input int len, input int mn, input int mx);
        bit trunc;
        bit short_f;
        int nout;
        trunc   = (mx != 0) && (len > mx);
        short_f = !trunc && (mn != 0) && (len < mn);
        nout    = trunc ? mx : len;
        for (int i = 0; i < nout; i++) begin
            exp_d.push_back(in_d[i]);
            exp_l.push_back(i == nout - 1);
            if (i == nout - 1) exp_u.push_back(trunc || short_f || in_u[i]);
            else               exp_u.push_back(in_u[i]);
        end
        exp_len.push_back(len > 65535 ? 65535 : len);
        exp_short.push_back(short_f);
        exp_long.push_back(trunc);
    endtask

    // Drives n_send beats of in_d/in_u (tlast on beat total), starting at posedge+1.
    task automatic send_frame(input int n_send, input int total, input int gap_max, input bit drain);
        int tmo;
        int g;
        for (int i = 0; i < n_send; i++) begin
            input_axis_tdata  = in_d[i];
            input_axis_tlast  = (i == total - 1);
            input_axis_tuser  = in_u[i];
            input_axis_tvalid = 1'b1;
            tmo = 0;
            @(negedge clk);
            while (!input_axis_tready && tmo < 100) begin
                @(negedge clk);
                tmo++;
            end
            checks++;
            if (tmo >= 100) begin
                failures++;
                $display("FAIL accept_timeout: beat %0d not accepted within %0d cycles", i, tmo);
            end
            @(posedge clk);
            #1;
            input_axis_tvalid = 1'b0;
            input_axis_tlast  = 1'b0;
            input_axis_tuser  = 1'b0;
            if (gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        end
        if (drain) begin
            tmo = 0;
            @(negedge clk);
            while (output_axis_tvalid && tmo < 200) begin
                @(negedge clk);
                tmo++;
            end
            checks++;
            if (tmo >= 200) begin
                failures++;
                $display("FAIL drain_timeout: output still valid after %0d cycles", tmo);
            end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_seq(input int len, input int base);
        in_d.delete();
        in_u.delete();
        for (int i = 0; i < len; i++) begin
            in_d.push_back(DW'(base + i));
            in_u.push_back(1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({output_axis_tvalid, output_axis_tlast, output_axis_tuser, frame_done,
             frame_bad_short, frame_bad_long} !== 6'b0 || output_axis_tdata !== 8'h00 ||
            frame_len !== 16'h0000 || input_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: ov=%0b d=%h done=%0b len=%0d in_ready=%0b, expected zeros and in_ready=1",
                     output_axis_tvalid, output_axis_tdata, frame_done, frame_len, input_axis_tready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (output_axis_tvalid !== 1'b0 || input_axis_tready !== 1'b1 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: ov=%0b in_ready=%0b done=%0b, expected 0 1 0",
                     output_axis_tvalid, input_axis_tready, frame_done);
        end
    endtask

    task automatic test_good_frame();
        clear_all();
        rdy_mode = 0; length_min = 16'd4; length_max = 16'd8;
        fill_seq(6, 1);
        send_frame(6, 6, 0, 1'b1);
        checks++;
        if (obs_d.size() != 6) begin
            failures++;
            $display("FAIL good_count: got %0d beats, expected 6", obs_d.size());
        end
        for (int i = 0; i < obs_d.size() && i < 6; i++) begin
            checks++;
            if (obs_d[i] !== DW'(i + 1) || obs_l[i] !== (i == 5) || obs_u[i] !== 1'b0 ||
                obs_cyc[i] != in_cyc[i] + 1) begin
                failures++;
                $display("FAIL good_beat%0d: got d=%h l=%0b u=%0b lat=%0d, expected d=%h l=%0b u=0 lat=1",
                         i, obs_d[i], obs_l[i], obs_u[i], obs_cyc[i] - in_cyc[i], DW'(i + 1), (i == 5));
            end
        end
        checks++;
        if (obs_len.size() != 1 || obs_len[0] != 6 || obs_short[0] || obs_long[0] ||
            obs_done_cyc[0] != in_cyc[5] + 1) begin
            failures++;
            $display("FAIL good_status: got %0d pulses len=%0d s=%0b l=%0b, expected 1 pulse len=6 flags 0 one cycle after tlast",
                     obs_len.size(), obs_len.size() ? obs_len[0] : -1,
                     obs_short.size() ? obs_short[0] : 1'b0, obs_long.size() ? obs_long[0] : 1'b0);
        end
    endtask

    task automatic test_short_frame();
        clear_all();
        rdy_mode = 0; length_min = 16'd4; length_max = 16'd8;
        fill_seq(2, 8'h20);
        send_frame(2, 2, 0, 1'b1);
        checks++;
        if (obs_d.size() != 2 || obs_d[0] !== 8'h20 || obs_u[0] !== 1'b0 ||
            obs_d[1] !== 8'h21 || obs_l[1] !== 1'b1 || obs_u[1] !== 1'b1) begin
            failures++;
            $display("FAIL short_beats: got %0d beats, last u=%0b, expected 2 beats last tlast=1 tuser=1",
                     obs_d.size(), obs_u.size() ? obs_u[obs_u.size() - 1] : 1'b0);
        end
        checks++;
        if (obs_len.size() != 1 || obs_len[0] != 2 || !obs_short[0] || obs_long[0]) begin
            failures++;
            $display("FAIL short_status: got %0d pulses, expected len=2 bad_short=1 bad_long=0", obs_len.size());
        end
    endtask

    task automatic test_long_frame();
        clear_all();
        rdy_mode = 0; length_min = 16'd0; length_max = 16'd8;
        fill_seq(12, 8'h40);
        send_frame(12, 12, 0, 1'b1);
        checks++;
        if (in_cyc.size() != 12) begin
            failures++;
            $display("FAIL long_accepted: got %0d accepted beats, expected 12", in_cyc.size());
        end
        checks++;
        if (obs_d.size() != 8) begin
            failures++;
            $display("FAIL long_count: got %0d output beats, expected 8", obs_d.size());
        end
        for (int i = 0; i < obs_d.size() && i < 8; i++) begin
            checks++;
            if (obs_d[i] !== DW'(8'h40 + i) || obs_l[i] !== (i == 7) || obs_u[i] !== (i == 7)) begin
                failures++;
                $display("FAIL long_beat%0d: got d=%h l=%0b u=%0b, expected d=%h l=%0b u=%0b",
                         i, obs_d[i], obs_l[i], obs_u[i], DW'(8'h40 + i), (i == 7), (i == 7));
            end
        end
        checks++;
        if (obs_len.size() != 1 || obs_len[0] != 12 || obs_short[0] || !obs_long[0] ||
            obs_done_cyc[0] != in_cyc[11] + 1) begin
            failures++;
            $display("FAIL long_status: got %0d pulses len=%0d, expected one pulse after beat 12 len=12 bad_long=1",
                     obs_len.size(), obs_len.size() ? obs_len[0] : -1);
        end
    endtask

    task automatic test_exact_max();
        clear_all();
        rdy_mode = 0; length_min = 16'd0; length_max = 16'd8;
        fill_seq(8, 8'h80);
        send_frame(8, 8, 0, 1'b1);
        checks++;
        if (obs_d.size() != 8 || obs_l[7] !== 1'b1 || obs_u[7] !== 1'b0 || obs_d[7] !== 8'h87) begin
            failures++;
            $display("FAIL exact_beats: got %0d beats, expected 8 ending 0x87 tlast=1 tuser=0", obs_d.size());
        end
        checks++;
        if (obs_len.size() != 1 || obs_len[0] != 8 || obs_short[0] || obs_long[0]) begin
            failures++;
            $display("FAIL exact_status: got %0d pulses, expected len=8 flags 0", obs_len.size());
        end
    endtask

    task automatic test_backpressure();
        clear_all();
        rdy_mode = 1; length_min = 16'd4; length_max = 16'd8;
        fill_seq(5, 8'hA0);
        send_frame(5, 5, 0, 1'b1);
        rdy_mode = 0;
        checks++;
        if (obs_d.size() != 5) begin
            failures++;
            $display("FAIL bp_count: got %0d beats, expected 5", obs_d.size());
        end
        for (int i = 0; i < obs_d.size() && i < 5; i++) begin
            checks++;
            if (obs_d[i] !== DW'(8'hA0 + i) || obs_l[i] !== (i == 4) || obs_u[i] !== 1'b0) begin
                failures++;
                $display("FAIL bp_beat%0d: got d=%h l=%0b u=%0b, expected d=%h l=%0b u=0",
                         i, obs_d[i], obs_l[i], obs_u[i], DW'(8'hA0 + i), (i == 4));
            end
        end
        checks++;
        if (obs_len.size() != 1 || obs_len[0] != 5 || obs_short[0] || obs_long[0]) begin
            failures++;
            $display("FAIL bp_status: got %0d pulses, expected len=5 flags 0", obs_len.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        rdy_mode = 0; length_min = 16'd3; length_max = 16'd6;
        fill_seq(4, 8'hC0);
        model_frame(4, 3, 6);
        send_frame(4, 4, 0, 1'b0);
        fill_seq(2, 8'hD0);
        model_frame(2, 3, 6);
        send_frame(2, 2, 0, 1'b1);
        checks++;
        if (obs_d.size() != exp_d.size() || obs_len.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d beats %0d pulses, expected %0d beats 2 pulses",
                     obs_d.size(), obs_len.size(), exp_d.size());
        end
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_u[i] !== exp_u[i]) begin
                failures++;
                $display("FAIL b2b_beat%0d: got d=%h l=%0b u=%0b, expected d=%h l=%0b u=%0b",
                         i, obs_d[i], obs_l[i], obs_u[i], exp_d[i], exp_l[i], exp_u[i]);
            end
        end
        for (int i = 0; i < obs_len.size() && i < 2; i++) begin
            checks++;
            if (obs_len[i] != exp_len[i] || obs_short[i] !== exp_short[i] || obs_long[i] !== exp_long[i]) begin
                failures++;
                $display("FAIL b2b_status%0d: got len=%0d s=%0b l=%0b, expected len=%0d s=%0b l=%0b",
                         i, obs_len[i], obs_short[i], obs_long[i], exp_len[i], exp_short[i], exp_long[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_all();
        rdy_mode = 0; length_min = 16'd4; length_max = 16'd8;
        fill_seq(6, 8'h50);
        send_frame(3, 6, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({output_axis_tvalid, output_axis_tlast, output_axis_tuser, frame_done,
             frame_bad_short, frame_bad_long} !== 6'b0 || output_axis_tdata !== 8'h00 ||
            frame_len !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset: ov=%0b d=%h done=%0b len=%0d, expected all 0 before any clock edge",
                     output_axis_tvalid, output_axis_tdata, frame_done, frame_len);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_all();
        length_min = 16'd0; length_max = 16'd0;
        fill_seq(3, 8'h60);
        send_frame(3, 3, 0, 1'b1);
        checks++;
        if (obs_d.size() != 3 || obs_d[0] !== 8'h60 || obs_l[2] !== 1'b1 || obs_u[2] !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_beats: got %0d beats, expected 3 starting 0x60", obs_d.size());
        end
        checks++;
        if (obs_len.size() != 1 || obs_len[0] != 3 || obs_short[0] || obs_long[0]) begin
            failures++;
            $display("FAIL post_reset_status: got %0d pulses len=%0d, expected len=3 flags 0",
                     obs_len.size(), obs_len.size() ? obs_len[0] : -1);
        end
    endtask

    task automatic test_random_frames();
        int len, mn, mx;
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            clear_all();
            len = $urandom_range(1, 20);
            mn  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            mx  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 14);
            in_d.delete();
            in_u.delete();
            for (int i = 0; i < len; i++) begin
                in_d.push_back(DW'($urandom));
                in_u.push_back($urandom_range(0, 7) == 0);
            end
            model_frame(len, mn, mx);
            length_min = LW'(mn);
            length_max = LW'(mx);
            send_frame(len, len, 2, 1'b1);
            checks++;
            if (obs_d.size() != exp_d.size() || obs_len.size() != 1) begin
                failures++;
                $display("FAIL rand%0d_count: got %0d beats %0d pulses, expected %0d beats 1 pulse (len=%0d min=%0d max=%0d)",
                         f, obs_d.size(), obs_len.size(), exp_d.size(), len, mn, mx);
            end
            for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
                checks++;
                if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_u[i] !== exp_u[i]) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d: got d=%h l=%0b u=%0b, expected d=%h l=%0b u=%0b",
                             f, i, obs_d[i], obs_l[i], obs_u[i], exp_d[i], exp_l[i], exp_u[i]);
                end
            end
            if (obs_len.size() >= 1) begin
                checks++;
                if (obs_len[0] != exp_len[0] || obs_short[0] !== exp_short[0] || obs_long[0] !== exp_long[0]) begin
                    failures++;
                    $display("FAIL rand%0d_status: got len=%0d s=%0b l=%0b, expected len=%0d s=%0b l=%0b",
                             f, obs_len[0], obs_short[0], obs_long[0], exp_len[0], exp_short[0], exp_long[0]);
                end
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        rst = 1'b1;
        input_axis_tdata  = 8'h00;
        input_axis_tvalid = 1'b0;
        input_axis_tlast  = 1'b0;
        input_axis_tuser  = 1'b0;
        length_min = 16'd0;
        length_max = 16'd0;
        test_reset();
        test_good_frame();
        test_short_frame();
        test_long_frame();
        test_exact_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
